// File: rtl/sphere_scene_store.sv
// sphere_scene_store
//   Double-buffered scene memory for the sphere ray tracer. The host fills the
//   shadow bank while the intersection pipeline streams enabled records out of
//   the active bank. Banks swap only on a frame boundary while the iterator is
//   idle, so a pixel never sees a partially written scene.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en/wr_idx/wr_sphere/wr_enable
//                     write one record + enable bit into the shadow bank
//   swap_req          latch a swap request (pulse)
//   frame_start       frame boundary; a pending swap executes here if idle
//   swap_done         one-cycle pulse the cycle after a swap executes
//   rd_start          start streaming the active bank (ignored while busy)
//   out_valid/out_ready/out_sphere/out_idx/out_last
//                     record stream; out_last marks the highest enabled slot
//   scan_done         one-cycle pulse after a scan (or empty scan) ends
//   busy              iterator not idle
//   active_count      number of enabled slots in the active bank
//   dbg_state         iterator state for checkers
//
// Stream handshake: a record transfers on every rising edge where
// out_valid && out_ready; while out_valid && !out_ready the record, index and
// last flag are held unchanged, and out_valid never drops without a transfer
// (except under reset).
module sphere_scene_store #(
  parameter int N_SPHERES = 8,
  parameter int X_B       = 16,
  parameter int Y_B       = 15,
  parameter int Z_B       = 15,
  parameter int R_B       = 6,
  parameter int C_B       = 12,
  parameter int IDX_B     = $clog2(N_SPHERES),
  parameter int SPH_B     = X_B + Y_B + Z_B + R_B + C_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_B-1:0] wr_idx,
  input  logic [SPH_B-1:0] wr_sphere,
  input  logic             wr_enable,
  input  logic             swap_req,
  input  logic             frame_start,
  output logic             swap_done,
  input  logic             rd_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SPH_B-1:0] out_sphere,
  output logic [IDX_B-1:0] out_idx,
  output logic             out_last,
  output logic             scan_done,
  output logic             busy,
  output logic [IDX_B:0]   active_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EMPTY = 2'd2
  } state_e;

  // Record storage is never reset; only the enable bits qualify it.
  logic [SPH_B-1:0]     mem_q [2][N_SPHERES];
  logic [N_SPHERES-1:0] en_q [2];
  logic [N_SPHERES-1:0] en_d [2];
  logic                 active_q, active_d;
  logic                 pending_q, pending_d;
  logic                 swap_done_q, swap_done_d;
  logic [IDX_B:0]       count_q, count_d;
  state_e               state_q, state_d;
  logic [IDX_B-1:0]     ptr_q, ptr_d;
  logic                 scan_done_q, scan_done_d;

  logic                 shadow;
  logic                 swap_exec;
  logic [N_SPHERES-1:0] active_mask;
  logic [IDX_B-1:0]     first_idx;
  logic [IDX_B-1:0]     next_idx;
  logic                 has_next;

  assign shadow      = ~active_q;
  assign swap_exec   = pending_q & frame_start & (state_q == ST_IDLE);
  assign active_mask = en_q[active_q];

  // Bank bookkeeping. The bank being cleared on a swap is the old active one;
  // a write in the swap cycle targets the old shadow bank, so the two never
  // collide and the written enable survives into the new active bank.
  always_comb begin
    en_d[0] = en_q[0];
    en_d[1] = en_q[1];
    if (swap_exec) en_d[active_q] = '0;
    if (wr_en)     en_d[shadow][wr_idx] = wr_enable;
    active_d    = active_q ^ swap_exec;
    pending_d   = swap_exec ? 1'b0 : (pending_q | swap_req);
    swap_done_d = swap_exec;
    count_d     = '0;
    for (int i = 0; i < N_SPHERES; i++) begin
      if (en_d[active_d][i]) count_d = count_d + (IDX_B+1)'(1);
    end
  end

  // Lowest enabled slot overall, and lowest enabled slot above the pointer.
  // Descending loop so the last hit is the lowest index.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = N_SPHERES - 1; i >= 0; i--) begin
      if (active_mask[i]) begin
        first_idx = IDX_B'(i);
        if (IDX_B'(i) > ptr_q) begin
          next_idx = IDX_B'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  // Iterator next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    scan_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          if (|active_mask) begin
            state_d = ST_SCAN;
            ptr_d   = first_idx;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          if (has_next) begin
            ptr_d = next_idx;
          end else begin
            state_d     = ST_IDLE;
            scan_done_d = 1'b1;
          end
        end
      end
      ST_EMPTY: begin
        state_d     = ST_IDLE;
        scan_done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q[0]     <= '0;
      en_q[1]     <= '0;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      en_q[0]     <= en_d[0];
      en_q[1]     <= en_d[1];
      active_q    <= active_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
      count_q     <= count_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      scan_done_q <= scan_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[shadow][wr_idx] <= wr_sphere;
  end

  // Stream outputs are gated so they read zero outside a scan.
  assign out_valid    = (state_q == ST_SCAN);
  assign out_sphere   = out_valid ? mem_q[active_q][ptr_q] : '0;
  assign out_idx      = out_valid ? ptr_q : '0;
  assign out_last     = out_valid & ~has_next;
  assign busy         = (state_q != ST_IDLE);
  assign swap_done    = swap_done_q;
  assign scan_done    = scan_done_q;
  assign active_count = count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sphere_scene_store.sv
// Directed-plus-random bench for sphere_scene_store. The reference model keeps
// both banks as plain arrays and derives each scan's expected record list
// straight from the active bank's enable bits.
module tb_sphere_scene_store;

  localparam int N     = 8;
  localparam int IDX_B = 3;
  localparam int SPH_B = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wr_en;
  logic [IDX_B-1:0] wr_idx;
  logic [SPH_B-1:0] wr_sphere;
  logic             wr_enable;
  logic             swap_req;
  logic             frame_start;
  logic             swap_done;
  logic             rd_start;
  logic             out_valid;
  logic             out_ready;
  logic [SPH_B-1:0] out_sphere;
  logic [IDX_B-1:0] out_idx;
  logic             out_last;
  logic             scan_done;
  logic             busy;
  logic [IDX_B:0]   active_count;
  logic [1:0]       dbg_state;

  sphere_scene_store dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_sphere(wr_sphere), .wr_enable(wr_enable),
    .swap_req(swap_req), .frame_start(frame_start), .swap_done(swap_done),
    .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_sphere(out_sphere), .out_idx(out_idx), .out_last(out_last),
    .scan_done(scan_done), .busy(busy), .active_count(active_count),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int               vec_cnt = 0;
  int               err_cnt = 0;
  bit               model_en  [2][N];
  logic [SPH_B-1:0] model_rec [2][N];
  int               act;
  logic [SPH_B-1:0] exp_q[$];
  int               exp_idx_q[$];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SPH_B-1:0] rnd_rec();
    return {$urandom(), $urandom()};
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < N; i++) if (model_en[act][i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    act = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) model_en[b][i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_slot(input int idx, input logic [SPH_B-1:0] rec, input bit en);
    wr_en     = 1'b1;
    wr_idx    = IDX_B'(idx);
    wr_sphere = rec;
    wr_enable = en;
    cycle();
    wr_en = 1'b0;
    model_en[1-act][idx]  = en;
    model_rec[1-act][idx] = rec;
  endtask

  task automatic write_scene_random();
    for (int i = 0; i < N; i++) write_slot(i, rnd_rec(), 1'($urandom_range(0, 1)));
  endtask

  // Assumes a request is already pending and the iterator is idle.
  task automatic exec_swap(input bit with_wr);
    int               idx;
    logic [SPH_B-1:0] rec;
    frame_start = 1'b1;
    if (with_wr) begin
      idx       = $urandom_range(0, N - 1);
      rec       = rnd_rec();
      wr_en     = 1'b1;
      wr_idx    = IDX_B'(idx);
      wr_sphere = rec;
      wr_enable = 1'b1;
      model_en[1-act][idx]  = 1'b1;
      model_rec[1-act][idx] = rec;
    end
    cycle();
    frame_start = 1'b0;
    wr_en       = 1'b0;
    act = 1 - act;
    for (int i = 0; i < N; i++) model_en[1-act][i] = 1'b0;
    check("swap_done_pulse", swap_done, 1);
    cycle();
    check("swap_done_clear", swap_done, 0);
    check("active_count", active_count, model_count());
  endtask

  task automatic swap_bank(input bit with_wr);
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    exec_swap(with_wr);
  endtask

  // One pixel scan. stall_idx: slot on which out_ready is held low 5 cycles.
  // rnd_ready: random backpressure and stray rd_start pulses while busy.
  // hold_fs: drive frame_start throughout the scan (a swap must not happen).
  // wr_mid: write slot 2 of the shadow bank while the scan runs.
  task automatic scan(input int stall_idx, input bit rnd_ready, input bit hold_fs, input bit wr_mid);
    int stalls = 0;
    bit done   = 1'b0;
    exp_q.delete();
    exp_idx_q.delete();
    for (int i = 0; i < N; i++) begin
      if (model_en[act][i]) begin
        exp_q.push_back(model_rec[act][i]);
        exp_idx_q.push_back(i);
      end
    end
    rd_start = 1'b1;
    cycle();
    rd_start = 1'b0;
    if (exp_q.size() == 0) begin
      check("empty_busy", busy, 1);
      check("empty_valid", out_valid, 0);
      check("empty_done_early", scan_done, 0);
      cycle();
      check("empty_done", scan_done, 1);
      check("empty_valid2", out_valid, 0);
      cycle();
      check("empty_done_clear", scan_done, 0);
      check("empty_idle", busy, 0);
      return;
    end
    check("first_valid", out_valid, 1);
    for (int c = 0; c < 300 && !done; c++) begin
      frame_start = hold_fs;
      if (wr_mid && c == 1) begin
        logic [SPH_B-1:0] rec;
        rec       = rnd_rec();
        wr_en     = 1'b1;
        wr_idx    = IDX_B'(2);
        wr_sphere = rec;
        wr_enable = 1'b1;
        model_en[1-act][2]  = 1'b1;
        model_rec[1-act][2] = rec;
      end else begin
        wr_en = 1'b0;
      end
      if (exp_idx_q[0] == stall_idx && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      rd_start = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, 64'(exp_idx_q[0]));
      check("out_sphere", out_sphere, exp_q[0]);
      check("out_last", out_last, 64'(exp_q.size() == 1));
      check("scan_done_mid", scan_done, 0);
      if (hold_fs) check("swap_while_busy", swap_done, 0);
      if (out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
      end
      cycle();
      if (exp_q.size() == 0) done = 1'b1;
    end
    frame_start = 1'b0;
    wr_en       = 1'b0;
    rd_start    = 1'b0;
    out_ready   = 1'b1;
    if (!done) check("scan_timeout", 0, 1);
    check("end_valid", out_valid, 0);
    check("end_scan_done", scan_done, 1);
    check("end_idle", busy, 0);
    cycle();
    check("scan_done_clear", scan_done, 0);
    if (hold_fs) check("swap_after_busy", swap_done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_sphere = '0; wr_enable = 1'b0;
    swap_req = 1'b0; frame_start = 1'b0; rd_start = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) cycle();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", active_count, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_sphere", out_sphere, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    rst = 1'b0;
    cycle();

    // Empty active bank.
    scan(-1, 1'b0, 1'b0, 1'b0);

    // Scene with slots 1, 4, 7 enabled.
    for (int i = 0; i < N; i++) write_slot(i, rnd_rec(), (i == 1 || i == 4 || i == 7));
    check("shadow_invisible", active_count, 0);
    swap_bank(1'b0);
    scan(-1, 1'b0, 1'b0, 1'b0);
    scan(4, 1'b0, 1'b0, 1'b0);
    scan(-1, 1'b1, 1'b0, 1'b0);

    // Swap requested and frame_start held during a scan, with a shadow write.
    swap_req = 1'b1;
    cycle();
    swap_req = 1'b0;
    scan(-1, 1'b0, 1'b1, 1'b1);
    check("no_swap_count", active_count, model_count());
    exec_swap(1'b0);
    scan(-1, 1'b0, 1'b0, 1'b0);

    // Swaps without writes expose cleared banks.
    swap_bank(1'b0);
    scan(-1, 1'b0, 1'b0, 1'b0);
    swap_bank(1'b0);
    scan(-1, 1'b0, 1'b0, 1'b0);

    // Random scenes, random backpressure, occasional swap-cycle writes.
    repeat (8) begin
      write_scene_random();
      swap_bank(1'($urandom_range(0, 1)));
      scan($urandom_range(0, N - 1), 1'b1, 1'b0, 1'b0);
    end

    // Reset while the second record is presented.
    for (int i = 0; i < N; i++) write_slot(i, rnd_rec(), (i == 0 || i == 3 || i == 5));
    swap_bank(1'b0);
    rd_start = 1'b1;
    cycle();
    rd_start  = 1'b0;
    out_ready = 1'b1;
    check("rstscan_idx0", out_idx, 0);
    cycle();
    check("rstscan_idx1", out_idx, 3);
    check("rstscan_valid1", out_valid, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_reset();
    check("rstscan_valid", out_valid, 0);
    check("rstscan_busy", busy, 0);
    check("rstscan_count", active_count, model_count());
    check("rstscan_done", scan_done, 0);
    cycle();
    check("rstscan_done2", scan_done, 0);
    check("rstscan_valid2", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
